line_fill_server: RTL and testbench
===================================

LINE_FILL_SERVER -- requirements
Module: line_fill_server

Interface
REQ-001 Parameter ID_BITS, default 2, width of req_id/resp_id; SHALL equal the requester's line-fill-buffer pointer width.
REQ-002 Parameter QUEUE_DEPTH, default 2, number of accepted, not-yet-started requests held.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  line request present.
REQ-006 req_ready  output  1  request queue can accept.
REQ-007 req_we  input  1  1 = line write, 0 = line read.
REQ-008 req_addr  input  28  line address (word address bits 29:2).
REQ-009 req_data  input  128  write line; word i in bits [32i+31:32i].
REQ-010 req_id  input  ID_BITS  tag returned with the read response.
REQ-011 resp_valid  output  1  read line available.
REQ-012 resp_ready  input  1  requester can take the response.
REQ-013 resp_data  output  128  read line, same word packing as req_data.
REQ-014 resp_id  output  ID_BITS  req_id of the request being answered.
REQ-015 mem_req  output  1  word access request to backing memory.
REQ-016 mem_we  output  1  word write strobe.
REQ-017 mem_addr  output  30  word address.
REQ-018 mem_wdata  output  32  write word.
REQ-019 mem_rdata  input  32  read word, valid only when mem_ack=1.
REQ-020 mem_ack  input  1  one-cycle completion pulse for the current mem access.

Function
REQ-021 Request SHALL be accepted in a cycle with req_valid && req_ready; req_ready SHALL be !queue_full (no same-cycle pop bypass when full).
REQ-022 Queue SHALL be FIFO; request order to memory and response order SHALL match acceptance order.
REQ-023 FSM states: IDLE, BEAT, RESP.
REQ-024 IDLE with queue non-empty: SHALL pop head, latch we/addr/data/id, clear beat counter, enter BEAT; mem_req SHALL be 1 in the following cycle.
REQ-025 BEAT: mem_req=1, mem_we=latched we, mem_addr={line_addr, beat[1:0]}, mem_wdata=word beat of latched data; beats SHALL be issued in ascending order 0..3.
REQ-026 mem_ack SHALL be accepted in any BEAT cycle, including the first cycle of a beat; on ack of a read beat, mem_rdata SHALL be stored into word beat of the line register.
REQ-027 On ack of beats 0..2, beat SHALL increment and mem_addr/mem_wdata SHALL present the next word the following cycle with mem_req held at 1.
REQ-028 On ack of beat 3: read -> RESP; write -> IDLE, no response generated.
REQ-029 RESP: resp_valid=1 with stable resp_data/resp_id until resp_valid && resp_ready; then IDLE.
REQ-030 mem_req SHALL be 0 in IDLE and RESP; mem_ack outside BEAT SHALL be ignored.
REQ-031 Latency with mem_ack tied high: accept at cycle 0 -> mem_req cycles 2..5 -> resp_valid at cycle 6.
REQ-032 Queue SHALL keep accepting while FSM is busy, up to QUEUE_DEPTH entries.

Reset
REQ-033 While rst=1: FSM=IDLE, queue empty, beat=0; outputs req_ready=0, resp_valid=0, mem_req=0, mem_we=0, resp_data/resp_id/mem_addr/mem_wdata=0.
REQ-034 rst mid-transfer SHALL abandon the active and queued requests with no response; req_ready SHALL return to 1 in the first cycle after rst deasserts.

Structure
REQ-035 lineaddr_t (28 bits), line_t (128 bits), w_t (32 bits) SHALL come from the shared Mem package.
REQ-036 Request queue SHALL be one sub-module, sync_fifo, parameterised on width and depth.

Verification
REQ-037 Single read, mem_ack tied 1, addr 0x0000010, id 2, memory word n = n -> mem_addr 0x40..0x43 cycles 2..5, resp_valid cycle 6, resp_data 0x00000043_00000042_00000041_00000040, resp_id 2.
REQ-038 Write addr 0x0000005, data 0xDDDD_CCCC_BBBB_AAAA per word, 2-cycle ack latency -> writes 0xAAAA..0xDDDD to 0x14..0x17, no resp_valid.
REQ-039 Three back-to-back reads, ids 0,1,3, resp_ready=0 -> req_ready drops after 2 accepted while first is in RESP; responses ids 0,1,3 in order once resp_ready=1.
REQ-040 resp_ready held 0 for 10 cycles -> resp_valid, resp_data, resp_id stable all 10 cycles; mem_req=0.
REQ-041 rst asserted during beat 2 of a read -> no resp_valid, mem_req=0 the cycle after rst, subsequent read returns correct data.

Source files
------------

// File: rtl/line_fill_server_pkg.sv
// Shared memory types for the line fill server: line/word/address types,
// the request record stored in the queue, FSM states and a word-select helper.
package line_fill_server_pkg;

    localparam int WORD_BITS      = 32;
    localparam int LINE_WORDS     = 4;
    localparam int LINE_ADDR_BITS = 28;

    typedef logic [LINE_ADDR_BITS-1:0]         lineaddr_t;
    typedef logic [WORD_BITS*LINE_WORDS-1:0]   line_t;
    typedef logic [WORD_BITS-1:0]              w_t;
    typedef logic [LINE_ADDR_BITS+1:0]         waddr_t;
    typedef logic [1:0]                        beat_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_RESP = 2'd2
    } lfs_state_t;

    // Request record held in the queue (the id is appended by the top,
    // since its width is a parameter of the server).
    typedef struct packed {
        logic      we;
        lineaddr_t addr;
        line_t     data;
    } line_req_t;

    // Select word idx of a line; word i lives in bits [32i+31:32i].
    function automatic w_t line_word(input line_t line, input beat_t idx);
        return line[{idx, 5'b00000} +: WORD_BITS];
    endfunction

endpackage

// File: rtl/line_fill_server_sync_fifo.sv
// Small synchronous FIFO used as the request queue of the line fill server.
// Head entry is visible combinationally; a push into a full queue is dropped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty
);

    localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_BITS = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]    storage [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [CNT_BITS-1:0] count;
    logic                do_push;
    logic                do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_BITS'(DEPTH));
    assign empty   = (count == '0);
    assign head    = storage[rd_ptr];

    function automatic logic [PTR_BITS-1:0] ptr_next(input logic [PTR_BITS-1:0] p);
        return (p == PTR_BITS'(DEPTH - 1)) ? '0 : p + PTR_BITS'(1);
    endfunction

    // Payload storage; no reset needed since occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_BITS'(1);
                2'b01:   count <= count - CNT_BITS'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/line_fill_server.sv
// Line fill server: queues line read/write requests and serves each one as
// four ascending word accesses to a word-wide backing memory. Reads return
// the assembled line with the requester's id; writes produce no response.
module line_fill_server
    import line_fill_server_pkg::*;
#(
    parameter int ID_BITS     = 2,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  lineaddr_t          req_addr,
    input  line_t              req_data,
    input  logic [ID_BITS-1:0] req_id,
    output logic               resp_valid,
    input  logic               resp_ready,
    output line_t              resp_data,
    output logic [ID_BITS-1:0] resp_id,
    output logic               mem_req,
    output logic               mem_we,
    output waddr_t             mem_addr,
    output w_t                 mem_wdata,
    input  w_t                 mem_rdata,
    input  logic               mem_ack
);

    localparam int ENTRY_BITS = ID_BITS + $bits(line_req_t);

    lfs_state_t          state;
    lfs_state_t          state_next;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ENTRY_BITS-1:0] push_entry;
    logic [ENTRY_BITS-1:0] head_entry;
    line_req_t           head_req;
    logic [ID_BITS-1:0]  head_id;

    logic                lat_we;
    lineaddr_t           lat_addr;
    logic [ID_BITS-1:0]  lat_id;
    line_t               line_reg;
    beat_t               beat;

    logic                beat_ack;
    logic                last_ack;

    assign push_entry          = {req_id, req_we, req_addr, req_data};
    assign {head_id, head_req} = head_entry;
    assign fifo_push           = req_valid && req_ready;
    assign beat_ack            = (state == ST_BEAT) && mem_ack;
    assign last_ack            = beat_ack && (beat == 2'd3);

    sync_fifo #(
        .WIDTH (ENTRY_BITS),
        .DEPTH (QUEUE_DEPTH)
    ) u_req_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_entry),
        .full      (fifo_full),
        .pop       (fifo_pop),
        .head      (head_entry),
        .empty     (fifo_empty)
    );

    // State register; reset abandons whatever transfer was in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and queue pop: start a request whenever idle and one is waiting.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = ST_BEAT;
                end
            end
            ST_BEAT: begin
                if (last_ack) begin
                    state_next = lat_we ? ST_IDLE : ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Active request registers: latch on pop, advance beats and collect read words on ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_we   <= 1'b0;
            lat_addr <= '0;
            lat_id   <= '0;
            line_reg <= '0;
            beat     <= '0;
        end else if (fifo_pop) begin
            lat_we   <= head_req.we;
            lat_addr <= head_req.addr;
            lat_id   <= head_id;
            line_reg <= head_req.data;
            beat     <= '0;
        end else if (beat_ack) begin
            if (!lat_we) begin
                line_reg[{beat, 5'b00000} +: WORD_BITS] <= mem_rdata;
            end
            if (beat != 2'd3) begin
                beat <= beat + 2'd1;
            end
        end
    end

    // Output decode; everything is forced low while reset is held.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        resp_id    = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (!rst) begin
            req_ready  = !fifo_full;
            resp_valid = (state == ST_RESP);
            resp_data  = line_reg;
            resp_id    = lat_id;
            if (state == ST_BEAT) begin
                mem_req   = 1'b1;
                mem_we    = lat_we;
                mem_addr  = {lat_addr, beat};
                mem_wdata = line_word(line_reg, beat);
            end
        end
    end

endmodule

// File: tb/tb_line_fill_server.sv
// Self-checking bench for line_fill_server: a word memory model answers the
// memory port, read responses are checked against a scoreboard queue.
module tb_line_fill_server;
    import line_fill_server_pkg::*;

    localparam int ID_BITS = 2;

    typedef struct packed {
        logic [ID_BITS-1:0] id;
        line_t              data;
    } resp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    lineaddr_t          req_addr;
    line_t              req_data;
    logic [ID_BITS-1:0] req_id;
    logic               resp_valid;
    logic               resp_ready;
    line_t              resp_data;
    logic [ID_BITS-1:0] resp_id;
    logic               mem_req;
    logic               mem_we;
    waddr_t             mem_addr;
    w_t                 mem_wdata;
    w_t                 mem_rdata;
    logic               mem_ack;

    int     passed = 0;
    int     total  = 0;
    resp_t  exp_q[$];
    waddr_t act_wr_addr_q[$];
    w_t     act_wr_data_q[$];

    logic   ack_tied = 1'b1;
    int     ack_lat  = 2;
    logic   ack_reg  = 1'b0;
    w_t     rdata_reg = '0;
    int     wait_cnt = 0;
    w_t     mem [256];

    line_fill_server #(
        .ID_BITS     (ID_BITS),
        .QUEUE_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_id     (req_id),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    assign mem_ack   = ack_tied ? 1'b1 : ack_reg;
    assign mem_rdata = ack_tied ? mem[mem_addr[7:0]] : rdata_reg;

    // Memory model with a fixed ack latency counted in cycles of mem_req.
    always @(negedge clk) begin
        ack_reg = 1'b0;
        if (!ack_tied && mem_req) begin
            wait_cnt++;
            if (wait_cnt >= ack_lat) begin
                ack_reg  = 1'b1;
                wait_cnt = 0;
                if (mem_we) begin
                    act_wr_addr_q.push_back(mem_addr);
                    act_wr_data_q.push_back(mem_wdata);
                    mem[mem_addr[7:0]] = mem_wdata;
                end else begin
                    rdata_reg = mem[mem_addr[7:0]];
                end
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Expected line for an untouched memory where word n holds n.
    function automatic line_t exp_line(input lineaddr_t a);
        line_t r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*32 +: 32] = w_t'({a, i[1:0]});
        end
        return r;
    endfunction

    // Present one request, wait (bounded) for acceptance, record reads in the scoreboard.
    task automatic send_req(input logic we, input lineaddr_t addr, input line_t data,
                            input logic [ID_BITS-1:0] id, output int waited);
        resp_t r;
        waited    = -1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_data  = data;
        req_id    = id;
        for (int i = 0; i < 20; i++) begin
            if (req_ready === 1'b1) begin
                waited = i;
                break;
            end
            @(negedge clk);
        end
        if (waited >= 0) begin
            @(posedge clk);
            if (!we) begin
                r.id   = id;
                r.data = exp_line(addr);
                exp_q.push_back(r);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_data   = '0;
        req_id     = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = w_t'(i);
        repeat (3) @(negedge clk);
        total++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0)
            $display("[TB] FAIL reset_ctrl: got ready=%b rv=%b mreq=%b mwe=%b expected all 0",
                     req_ready, resp_valid, mem_req, mem_we);
        else passed++;
        total++;
        if (resp_data !== '0 || resp_id !== '0 || mem_addr !== '0 || mem_wdata !== '0)
            $display("[TB] FAIL reset_data: got rdata=%h rid=%h maddr=%h mwdata=%h expected 0",
                     resp_data, resp_id, mem_addr, mem_wdata);
        else passed++;
        rst = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1)
            $display("[TB] FAIL reset_release_ready: got %b expected 1", req_ready);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        int    waited;
        resp_t e;
        ack_tied = 1'b1;
        send_req(1'b0, 28'h0000010, '0, 2'd2, waited);
        total++;
        if (waited !== 0) $display("[TB] FAIL read_accept: got wait %0d expected 0", waited);
        else passed++;
        total++;
        if (mem_req !== 1'b0) $display("[TB] FAIL read_cycle1_mem_req: got %b expected 0", mem_req);
        else passed++;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== waddr_t'(32'h40 + c))
                $display("[TB] FAIL read_beat%0d: got req=%b we=%b addr=%h expected req=1 we=0 addr=%h",
                         c, mem_req, mem_we, mem_addr, 32'h40 + c);
            else passed++;
        end
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b1) $display("[TB] FAIL read_resp_cycle6: got %b expected 1", resp_valid);
        else passed++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        total++;
        if (resp_data !== e.data || resp_id !== e.id ||
            resp_data !== 128'h00000043_00000042_00000041_00000040)
            $display("[TB] FAIL read_resp_data: got id=%0d data=%h expected id=%0d data=%h",
                     resp_id, resp_data, e.id, e.data);
        else passed++;
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b0 || mem_req !== 1'b0)
            $display("[TB] FAIL read_after_handshake: got rv=%b mreq=%b expected 0 0", resp_valid, mem_req);
        else passed++;
    endtask

    task automatic test_write();
        int     waited;
        logic   saw_resp;
        waddr_t wa;
        w_t     wd;
        ack_tied = 1'b0;
        ack_lat  = 2;
        saw_resp = 1'b0;
        act_wr_addr_q.delete();
        act_wr_data_q.delete();
        send_req(1'b1, 28'h0000005, {32'h0000DDDD, 32'h0000CCCC, 32'h0000BBBB, 32'h0000AAAA},
                 2'd1, waited);
        total++;
        if (waited !== 0) $display("[TB] FAIL write_accept: got wait %0d expected 0", waited);
        else passed++;
        for (int i = 0; i < 30; i++) begin
            if (resp_valid === 1'b1) saw_resp = 1'b1;
            @(negedge clk);
        end
        total++;
        if (saw_resp !== 1'b0) $display("[TB] FAIL write_no_resp: got resp_valid=1 expected 0");
        else passed++;
        total++;
        if (act_wr_addr_q.size() != 4)
            $display("[TB] FAIL write_count: got %0d expected 4", act_wr_addr_q.size());
        else passed++;
        for (int i = 0; i < 4; i++) begin
            wa = (act_wr_addr_q.size() > 0) ? act_wr_addr_q.pop_front() : '1;
            wd = (act_wr_data_q.size() > 0) ? act_wr_data_q.pop_front() : '1;
            total++;
            if (wa !== waddr_t'(32'h14 + i) || wd !== w_t'(32'hAAAA + 32'h1111 * i))
                $display("[TB] FAIL write_word%0d: got addr=%h data=%h expected addr=%h data=%h",
                         i, wa, wd, 32'h14 + i, 32'hAAAA + 32'h1111 * i);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int           waited;
        int           found;
        logic [1:0]   ids [3];
        ids[0] = 2'd0;
        ids[1] = 2'd1;
        ids[2] = 2'd3;
        ack_tied   = 1'b1;
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send_req(1'b0, lineaddr_t'(32'h20 + k), '0, ids[k], waited);
            total++;
            if (waited !== 0) $display("[TB] FAIL b2b_accept%0d: got wait %0d expected 0", k, waited);
            else passed++;
        end
        found = 0;
        for (int i = 0; i < 30; i++) begin
            if (resp_valid === 1'b1) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (found != 1) $display("[TB] FAIL b2b_first_resp: got no resp_valid within bound expected 1");
        else passed++;
        total++;
        if (req_ready !== 1'b0) $display("[TB] FAIL b2b_queue_full: got req_ready=%b expected 0", req_ready);
        else passed++;
    endtask

    task automatic test_resp_hold();
        resp_t e;
        e = (exp_q.size() > 0) ? exp_q[0] : '0;
        for (int i = 0; i < 10; i++) begin
            total++;
            if (resp_valid !== 1'b1 || resp_data !== e.data || resp_id !== e.id || mem_req !== 1'b0)
                $display("[TB] FAIL hold_cycle%0d: got rv=%b id=%0d data=%h mreq=%b expected rv=1 id=%0d data=%h mreq=0",
                         i, resp_valid, resp_id, resp_data, mem_req, e.id, e.data);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_drain();
        int    n;
        resp_t e;
        n = 0;
        resp_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (resp_valid === 1'b1) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                total++;
                if (resp_id !== e.id || resp_data !== e.data)
                    $display("[TB] FAIL drain_resp%0d: got id=%0d data=%h expected id=%0d data=%h",
                             n, resp_id, resp_data, e.id, e.data);
                else passed++;
                n++;
                if (n == 3) begin
                    @(negedge clk);
                    break;
                end
            end
            @(negedge clk);
        end
        total++;
        if (n != 3) $display("[TB] FAIL drain_count: got %0d expected 3", n);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int    waited;
        int    found;
        logic  saw_resp;
        resp_t e;
        ack_tied = 1'b0;
        ack_lat  = 2;
        send_req(1'b0, 28'h0000030, '0, 2'd1, waited);
        found = 0;
        for (int i = 0; i < 30; i++) begin
            if (mem_req === 1'b1 && mem_addr === waddr_t'(32'hC2)) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (found != 1) $display("[TB] FAIL rstmid_reach_beat2: got no beat 2 within bound expected 1");
        else passed++;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        total++;
        if (mem_req !== 1'b0 || resp_valid !== 1'b0)
            $display("[TB] FAIL rstmid_outputs: got mreq=%b rv=%b expected 0 0", mem_req, resp_valid);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1) $display("[TB] FAIL rstmid_ready: got %b expected 1", req_ready);
        else passed++;
        saw_resp = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1 || mem_req === 1'b1) saw_resp = 1'b1;
        end
        total++;
        if (saw_resp !== 1'b0) $display("[TB] FAIL rstmid_abandon: got activity after reset expected none");
        else passed++;
        send_req(1'b0, 28'h0000031, '0, 2'd3, waited);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid === 1'b1) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        total++;
        if (found != 1 || resp_id !== e.id || resp_data !== e.data)
            $display("[TB] FAIL rstmid_next_read: got found=%0d id=%0d data=%h expected found=1 id=%0d data=%h",
                     found, resp_id, resp_data, e.id, e.data);
        else passed++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_back_to_back();
        test_resp_hold();
        test_drain();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
